video_clken_gen: RTL and testbench

//  Parametrised, runtime-reprogrammable clock-enable generator for the video subsystem.

---
 rtl/video_clken_gen.sv | 153 +++++++++++++++
 tb/tb_video_clken_gen.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/video_clken_gen.sv
// -----------------------------------------------------------------------------
// video_clken_gen
//
// Fractional-rate clock-enable generator for the video subsystem. Each of the
// NUM_CH channels runs a phase accumulator clocked by refclk. The accumulator
// carry becomes a one-cycle enable pulse (clken). The accumulator MSB becomes
// an approximately 50% duty square wave (outclk). Output rate is
// f_refclk * inc / 2^ACC_W. Increments can be reprogrammed at run time.
// locked reports that no increment has been written for LOCK_CYCLES cycles.
//
// Optional feature (compile-time macro VIDEO_CLKEN_SYNC_EN):
//   Adds the sync_in port. sync_in=1 at an edge zeroes every accumulator and
//   clears clken/outclk at that edge, which realigns all channel phases.
//   Lock state is not affected by sync_in.
//   Without the macro, the port and the realign logic are absent and the
//   accumulators free-run.
//
// Ports:
//   refclk   in   1       clock, all logic on the rising edge
//   rst      in   1       asynchronous active-high reset
//   cfg_we   in   1       config write strobe, one cycle wide
//   cfg_ch   in   3       target channel; indices >= NUM_CH are ignored
//   cfg_inc  in   ACC_W   new phase increment for the target channel
//   sync_in  in   1       phase realign request (VIDEO_CLKEN_SYNC_EN only)
//   clken    out  NUM_CH  per-channel one-cycle enable pulse
//   outclk   out  NUM_CH  per-channel accumulator MSB
//   locked   out  1       all increments stable for LOCK_CYCLES cycles
// -----------------------------------------------------------------------------
module video_clken_gen #(
  parameter int NUM_CH      = 3,
  parameter int ACC_W       = 24,
  parameter int LOCK_CYCLES = 1024,
  parameter logic [NUM_CH*ACC_W-1:0] INC_INIT = {24'h4CCCCD, 24'h800000, 24'h800000}
) (
  input  logic              refclk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [2:0]        cfg_ch,
  input  logic [ACC_W-1:0]  cfg_inc,
`ifdef VIDEO_CLKEN_SYNC_EN
  input  logic              sync_in,
`endif
  output logic [NUM_CH-1:0] clken,
  output logic [NUM_CH-1:0] outclk,
  output logic              locked
);

  localparam int               CNT_W     = $clog2(LOCK_CYCLES);
  localparam logic [CNT_W-1:0] LOCK_TERM = CNT_W'(LOCK_CYCLES - 1);
  localparam logic [3:0]       NUM_CH_W  = 4'(NUM_CH);

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_t;

  logic [ACC_W-1:0] acc [NUM_CH];
  logic [ACC_W-1:0] inc [NUM_CH];
  logic [ACC_W:0]   sum [NUM_CH];

  lock_state_t      lock_state;
  logic [CNT_W-1:0] lock_cnt;
  logic             cfg_wr_valid;
  logic             realign;

  // Out-of-range channel indices are dropped, so they never disturb lock.
  assign cfg_wr_valid = cfg_we && ({1'b0, cfg_ch} < NUM_CH_W);

`ifdef VIDEO_CLKEN_SYNC_EN
  assign realign = sync_in;
`else
  assign realign = 1'b0;
`endif

  // One extra bit holds the carry out of each accumulator add.
  always_comb begin
    // NOTE: every always_comb output gets a value on every path (here the loop
    // covers every element); a path that leaves one unassigned infers a latch.
    for (int i = 0; i < NUM_CH; i++) begin
      sum[i] = {1'b0, acc[i]} + {1'b0, inc[i]};
    end
  end

  // Accumulators, increment registers and registered outputs.
  // A write updates inc at this edge but leaves acc untouched.
  // The add at this edge still uses the old increment, so the phase carries
  // across a rate change without a glitch.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      // NOTE: the increment array is reset on purpose. It is a small bank of
      // flops holding the power-up rates, not a RAM, so each channel comes out
      // of reset at its INC_INIT rate.
      for (int i = 0; i < NUM_CH; i++) begin
        acc[i] <= '0;
        inc[i] <= INC_INIT[i*ACC_W +: ACC_W];
      end
      clken  <= '0;
      outclk <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        // NOTE: sequential state uses non-blocking assignments only. Every
        // register then samples its pre-edge inputs, whatever the statement
        // order.
        if (cfg_wr_valid && (cfg_ch == 3'(i))) begin
          inc[i] <= cfg_inc;
        end
        if (realign) begin
          acc[i]    <= '0;
          clken[i]  <= 1'b0;
          outclk[i] <= 1'b0;
        end else begin
          acc[i]    <= sum[i][ACC_W-1:0];
          clken[i]  <= sum[i][ACC_W];
          outclk[i] <= sum[i][ACC_W-1];
        end
      end
    end
  end

  // Lock tracker. Any valid write restarts the stability window. A write wins
  // over the terminal count when both happen in the same cycle.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      lock_state <= UNLOCKED;
      lock_cnt   <= '0;
      locked     <= 1'b0;
    end else if (cfg_wr_valid) begin
      lock_state <= UNLOCKED;
      lock_cnt   <= '0;
      locked     <= 1'b0;
    end else begin
      case (lock_state)
        UNLOCKED: begin
          if (lock_cnt == LOCK_TERM) begin
            lock_state <= LOCKED;
            locked     <= 1'b1;
          end else begin
            lock_cnt <= lock_cnt + CNT_W'(1);
          end
        end
        LOCKED: begin
          locked <= 1'b1;
        end
        default: begin
          lock_state <= UNLOCKED;
          lock_cnt   <= '0;
          locked     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_video_clken_gen.sv
// -----------------------------------------------------------------------------
// tb_video_clken_gen
//
// Scoreboard bench for video_clken_gen with NUM_CH=3, ACC_W=24 and
// LOCK_CYCLES=16. The stimulus process pushes hand-computed expectations. Each
// expectation is tagged with the refclk edge after which it holds. A monitor
// samples the outputs on every falling edge and retires the expectations that
// are due.
//
// Cycle numbers are measured from reset release (R). No write touches ch2
// before the second reset, and its increment 0x4CCCCD is just above 0.3*2^24.
// Over any window whose ends are multiples of 10 edges from R, ch2 therefore
// pulses exactly 3 times per 10 cycles.
// -----------------------------------------------------------------------------
module tb_video_clken_gen;

  localparam int NUM_CH      = 3;
  localparam int ACC_W       = 24;
  localparam int LOCK_CYCLES = 16;

  typedef enum {K_VEC, K_CKN, K_LCK, K_CLR, K_CNT, K_TOG} kind_e;

  typedef struct {
    int    cyc;
    kind_e kind;
    string name;
    int    ch;
    int    val;
  } exp_t;

  logic              refclk  = 1'b0;
  logic              rst     = 1'b1;
  logic              cfg_we  = 1'b0;
  logic [2:0]        cfg_ch  = '0;
  logic [ACC_W-1:0]  cfg_inc = '0;
  logic              sync_in = 1'b0;
  logic [NUM_CH-1:0] clken;
  logic [NUM_CH-1:0] outclk;
  logic              locked;

  int          edge_cnt = 0;
  int          n_checks = 0;
  int          n_pass   = 0;
  int          pulse_cnt [NUM_CH];
  int          tog_cnt   [NUM_CH];
  logic [2:0]  prev_out = '0;
  logic [6:0]  obs_vec;
  exp_t        sb [$];
  exp_t        cur;
  int          r0;
  int          r2;
  int          last_cyc;

  video_clken_gen #(
    .NUM_CH      (NUM_CH),
    .ACC_W       (ACC_W),
    .LOCK_CYCLES (LOCK_CYCLES)
  ) dut (
    .refclk  (refclk),
    .rst     (rst),
    .cfg_we  (cfg_we),
    .cfg_ch  (cfg_ch),
    .cfg_inc (cfg_inc),
`ifdef VIDEO_CLKEN_SYNC_EN
    .sync_in (sync_in),
`endif
    .clken   (clken),
    .outclk  (outclk),
    .locked  (locked)
  );

  always #5 refclk = ~refclk;

  always @(posedge refclk) edge_cnt <= edge_cnt + 1;

  task automatic check(string name, int actual, int expected);
    n_checks++;
    if (actual == expected) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, actual, expected, edge_cnt);
  endtask

  function automatic void push(int cyc, kind_e kind, string name, int ch, int val);
    exp_t e;
    e.cyc  = cyc;
    e.kind = kind;
    e.name = name;
    e.ch   = ch;
    e.val  = val;
    sb.push_back(e);
  endfunction

  // Pulse and toggle counts since the last K_CLR marker. A marker at edge c
  // counts samples taken after edges c+1 onward.
  always @(negedge refclk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (clken[c]) pulse_cnt[c]++;
      if (outclk[c] !== prev_out[c]) tog_cnt[c]++;
    end
    prev_out = outclk;
    obs_vec  = {clken, outclk, locked};
    while (sb.size() > 0 && sb[0].cyc <= edge_cnt) begin
      cur = sb.pop_front();
      case (cur.kind)
        K_VEC: check(cur.name, int'(obs_vec), cur.val);
        K_CKN: check(cur.name, int'(clken), cur.val);
        K_LCK: check(cur.name, int'(locked), cur.val);
        K_CNT: check(cur.name, pulse_cnt[cur.ch], cur.val);
        K_TOG: check(cur.name, tog_cnt[cur.ch], cur.val);
        K_CLR: begin
          for (int c = 0; c < NUM_CH; c++) begin
            pulse_cnt[c] = 0;
            tog_cnt[c]   = 0;
          end
        end
        default: ;
      endcase
    end
  end

  task automatic wait_edge(int target);
    while (edge_cnt < target) begin
      @(posedge refclk);
      #1;
    end
  endtask

  task automatic cfg_write(int at_edge, logic [2:0] ch, logic [ACC_W-1:0] inc);
    wait_edge(at_edge - 1);
    cfg_we  = 1'b1;
    cfg_ch  = ch;
    cfg_inc = inc;
    wait_edge(at_edge);
    cfg_we  = 1'b0;
    cfg_ch  = '0;
    cfg_inc = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish by 100000ns, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(posedge refclk);
    #1;
    rst = 1'b0;
    r0  = edge_cnt;

    // Vectors are {clken[2:0], outclk[2:0], locked}.
    // Test 1: reset defaults, first pulses, rates, lock time.
    push(r0,       K_VEC, "t1_reset_state",  0, 7'b000_000_0);
    push(r0,       K_CLR, "",                0, 0);
    push(r0 + 1,   K_VEC, "t1_edge1",        0, 7'b000_011_0);
    push(r0 + 2,   K_VEC, "t1_edge2",        0, 7'b011_100_0);
    push(r0 + 15,  K_LCK, "t1_unlocked_15",  0, 0);
    push(r0 + 16,  K_LCK, "t1_locked_16",    0, 1);
    push(r0 + 100, K_CNT, "t1_ch0_pulses",   0, 50);
    push(r0 + 100, K_CNT, "t1_ch1_pulses",   1, 50);
    push(r0 + 100, K_CNT, "t1_ch2_pulses",   2, 30);
    // Test 2: ch1 rate change to 1/4, lock drop and relock.
    push(r0 + 120, K_CLR, "",                0, 0);
    push(r0 + 120, K_LCK, "t2_lock_drop",    0, 0);
    push(r0 + 122, K_CKN, "t2_clken_122",    0, 3'b001);
    push(r0 + 124, K_CKN, "t2_clken_124",    0, 3'b111);
    push(r0 + 135, K_LCK, "t2_unlocked_15",  0, 0);
    push(r0 + 136, K_LCK, "t2_relocked_16",  0, 1);
    push(r0 + 220, K_CNT, "t2_ch0_pulses",   0, 50);
    push(r0 + 220, K_CNT, "t2_ch1_pulses",   1, 25);
    push(r0 + 220, K_CNT, "t2_ch2_pulses",   2, 30);
    // Test 3: write to channel 3 is ignored.
    push(r0 + 240, K_CLR, "",                0, 0);
    push(r0 + 240, K_LCK, "t3_lock_kept",    0, 1);
    push(r0 + 340, K_CNT, "t3_ch0_pulses",   0, 50);
    push(r0 + 340, K_CNT, "t3_ch1_pulses",   1, 25);
    push(r0 + 340, K_CNT, "t3_ch2_pulses",   2, 30);
    push(r0 + 340, K_LCK, "t3_lock_still",   0, 1);
    // Test 4: ch0 increment 0, then the full-scale increment.
    push(r0 + 350, K_CLR, "",                0, 0);
    push(r0 + 550, K_CNT, "t4_ch0_inc0",     0, 0);
    push(r0 + 550, K_TOG, "t4_ch0_outclk",   0, 0);
    push(r0 + 550, K_CNT, "t4_ch1_pulses",   1, 50);
    push(r0 + 550, K_CNT, "t4_ch2_pulses",   2, 60);
    push(r0 + 560, K_CLR, "",                0, 0);
    push(r0 + 660, K_CNT, "t4_ch0_incmax",   0, 99);
    push(r0 + 670, K_LCK, "t5_locked_pre",   0, 1);
    // Test 5: async reset between edges clears the outputs at once.
    push(r0 + 680, K_VEC, "t5_async_rst",    0, 7'b000_000_0);

    cfg_write(r0 + 120, 3'd1, 24'h400000);
    cfg_write(r0 + 240, 3'd3, 24'h000000);
    cfg_write(r0 + 350, 3'd0, 24'h000000);
    cfg_write(r0 + 560, 3'd0, 24'hFFFFFF);

    wait_edge(r0 + 680);
    #2;
    rst = 1'b1;
    wait_edge(r0 + 690);
    rst = 1'b0;
    r2  = edge_cnt;

    push(r2,       K_VEC, "t5_reset_state",  0, 7'b000_000_0);
    push(r2,       K_CLR, "",                0, 0);
    push(r2 + 1,   K_VEC, "t5_edge1",        0, 7'b000_011_0);
    push(r2 + 15,  K_LCK, "t5_unlocked_15",  0, 0);
    push(r2 + 16,  K_LCK, "t5_relocked_16",  0, 1);
    push(r2 + 100, K_CNT, "t5_ch0_pulses",   0, 50);
    push(r2 + 100, K_CNT, "t5_ch1_pulses",   1, 50);
    push(r2 + 100, K_CNT, "t5_ch2_pulses",   2, 30);
    last_cyc = r2 + 100;

`ifdef VIDEO_CLKEN_SYNC_EN
    // Test 6: realign at R2+125, then a realign combined with a ch2 write at R2+141.
    push(r2 + 125, K_VEC, "t6_sync_edge",    0, 7'b000_000_1);
    push(r2 + 126, K_VEC, "t6_sync_p1",      0, 7'b000_011_1);
    push(r2 + 127, K_VEC, "t6_sync_p2",      0, 7'b011_100_1);
    push(r2 + 128, K_CKN, "t6_sync_p3",      0, 3'b000);
    push(r2 + 129, K_CKN, "t6_sync_p4",      0, 3'b111);
    push(r2 + 141, K_VEC, "t6_sync_wr",      0, 7'b000_000_0);
    push(r2 + 142, K_VEC, "t6_sync_wr_p1",   0, 7'b000_111_0);
    push(r2 + 143, K_VEC, "t6_sync_wr_p2",   0, 7'b111_000_0);
    last_cyc = r2 + 143;

    wait_edge(r2 + 124);
    sync_in = 1'b1;
    wait_edge(r2 + 125);
    sync_in = 1'b0;
    wait_edge(r2 + 140);
    sync_in = 1'b1;
    cfg_we  = 1'b1;
    cfg_ch  = 3'd2;
    cfg_inc = 24'h800000;
    wait_edge(r2 + 141);
    sync_in = 1'b0;
    cfg_we  = 1'b0;
    cfg_ch  = '0;
    cfg_inc = '0;
`endif

    wait_edge(last_cyc + 3);
    check("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
